// File: rtl/mem_bank.sv
// rtl/mem_bank.sv - DEPTH x WIDTH register bank with write ack, registered read and sequenced bulk clear
module mem_bank #(
    parameter int                 WIDTH   = 6,
    parameter int                 DEPTH   = 8,
    parameter logic [WIDTH-1:0]   RST_VAL = {WIDTH{1'b1}},
    parameter bit                 BYPASS  = 1'b1,
    localparam int                AW      = $clog2(DEPTH)
) (
    input  logic             in_clk,
    input  logic             in_rst,
    input  logic             mem_wrt_en,
    input  logic [AW-1:0]    in_wrt_addr,
    input  logic [WIDTH-1:0] in_mem,
    output logic             mem_wrt_rd,
    input  logic             in_rd_en,
    input  logic [AW-1:0]    in_rd_addr,
    output logic [WIDTH-1:0] out_mem,
    output logic             out_rd_vld,
    input  logic             in_clr,
    output logic             out_busy,
    output logic             out_err
);

    typedef enum logic {IDLE, CLEAR} state_t;

    localparam logic [AW:0]   DEPTH_W  = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] LAST_PTR = AW'(DEPTH - 1);

    state_t            state_q, state_d;
    logic [AW-1:0]     ptr_q, ptr_d;
    logic [WIDTH-1:0]  mem_q [DEPTH];
    logic [WIDTH-1:0]  rd_data_q, rd_data_d;
    logic              rd_vld_q, ack_q, err_q;

    logic idle, wr_addr_ok, rd_addr_ok, wr_req, wr_go, wr_bad, rd_go, collide;

    assign idle       = (state_q == IDLE);
    assign wr_addr_ok = ({1'b0, in_wrt_addr} < DEPTH_W);
    assign rd_addr_ok = ({1'b0, in_rd_addr} < DEPTH_W);
    // A clear request in the same cycle swallows the write silently.
    assign wr_req     = idle && mem_wrt_en && !in_clr;
    assign wr_go      = wr_req && wr_addr_ok;
    assign wr_bad     = wr_req && !wr_addr_ok;
    assign rd_go      = idle && in_rd_en;
    assign collide    = wr_go && rd_addr_ok && (in_rd_addr == in_wrt_addr);

    always_comb begin
        rd_data_d = rd_data_q;
        if (rd_go) begin
            if (!rd_addr_ok)
                rd_data_d = RST_VAL;
            else if (BYPASS && collide)
                rd_data_d = in_mem;
            else
                rd_data_d = mem_q[in_rd_addr];
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        case (state_q)
            IDLE: begin
                if (in_clr) begin
                    state_d = CLEAR;
                    ptr_d   = '0;
                end
            end
            CLEAR: begin
                ptr_d = ptr_q + 1'b1;
                if (ptr_q == LAST_PTR) begin
                    state_d = IDLE;
                    ptr_d   = '0;
                end
            end
            default: begin
                state_d = IDLE;
                ptr_d   = '0;
            end
        endcase
    end

    always_ff @(posedge in_clk or negedge in_rst) begin
        if (!in_rst) begin
            state_q <= IDLE;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
        end
    end

    always_ff @(posedge in_clk or negedge in_rst) begin
        if (!in_rst) begin
            for (int i = 0; i < DEPTH; i++)
                mem_q[i] <= RST_VAL;
        end else if (state_q == CLEAR) begin
            mem_q[ptr_q] <= RST_VAL;
        end else if (wr_go) begin
            mem_q[in_wrt_addr] <= in_mem;
        end
    end

    always_ff @(posedge in_clk or negedge in_rst) begin
        if (!in_rst) begin
            rd_data_q <= RST_VAL;
            rd_vld_q  <= 1'b0;
            ack_q     <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            rd_data_q <= rd_data_d;
            rd_vld_q  <= rd_go;
            ack_q     <= wr_go;
            err_q     <= wr_bad || (rd_go && !rd_addr_ok);
        end
    end

    assign out_mem    = rd_data_q;
    assign out_rd_vld = rd_vld_q;
    assign mem_wrt_rd = ack_q;
    assign out_err    = err_q;
    assign out_busy   = (state_q == CLEAR);

endmodule

// File: tb/tb_mem_bank.sv
// tb/tb_mem_bank.sv - scoreboard bench for mem_bank (DEPTH=8/BYPASS=1 and DEPTH=6/BYPASS=0)
module tb_mem_bank;

    typedef struct {
        logic [5:0] mem;
        logic       vld;
        logic       ack;
        logic       err;
        logic       busy;
    } exp_t;

    logic       in_clk = 1'b0;
    logic       in_rst;
    logic       mem_wrt_en;
    logic [2:0] in_wrt_addr;
    logic [5:0] in_mem;
    logic       in_rd_en;
    logic [2:0] in_rd_addr;
    logic       in_clr;

    logic [5:0] oa_mem, ob_mem;
    logic       oa_ack, oa_vld, oa_busy, oa_err;
    logic       ob_ack, ob_vld, ob_busy, ob_err;

    int checks   = 0;
    int failures = 0;

    exp_t       sb[$];
    logic [5:0] mm [2][8];
    logic [5:0] omem_m [2];
    bit         busy_m [2];
    int         ptr_m  [2];
    int         dep    [2] = '{8, 6};
    bit         byp    [2] = '{1'b1, 1'b0};

    always #5 in_clk = ~in_clk;

    mem_bank #(.WIDTH(6), .DEPTH(8), .BYPASS(1'b1)) dut_a (
        .in_clk(in_clk), .in_rst(in_rst), .mem_wrt_en(mem_wrt_en), .in_wrt_addr(in_wrt_addr),
        .in_mem(in_mem), .mem_wrt_rd(oa_ack), .in_rd_en(in_rd_en), .in_rd_addr(in_rd_addr),
        .out_mem(oa_mem), .out_rd_vld(oa_vld), .in_clr(in_clr), .out_busy(oa_busy), .out_err(oa_err)
    );

    mem_bank #(.WIDTH(6), .DEPTH(6), .BYPASS(1'b0)) dut_b (
        .in_clk(in_clk), .in_rst(in_rst), .mem_wrt_en(mem_wrt_en), .in_wrt_addr(in_wrt_addr),
        .in_mem(in_mem), .mem_wrt_rd(ob_ack), .in_rd_en(in_rd_en), .in_rd_addr(in_rd_addr),
        .out_mem(ob_mem), .out_rd_vld(ob_vld), .in_clr(in_clr), .out_busy(ob_busy), .out_err(ob_err)
    );

    function automatic exp_t get_obs(int k);
        exp_t o;
        if (k == 0) begin
            o.mem = oa_mem; o.vld = oa_vld; o.ack = oa_ack; o.err = oa_err; o.busy = oa_busy;
        end else begin
            o.mem = ob_mem; o.vld = ob_vld; o.ack = ob_ack; o.err = ob_err; o.busy = ob_busy;
        end
        return o;
    endfunction

    task automatic chk(string tag, logic [5:0] obs, logic [5:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cmp(string tag, int k, exp_t e);
        exp_t o;
        o = get_obs(k);
        chk($sformatf("%s[%0d].mem", tag, k), o.mem, e.mem);
        chk($sformatf("%s[%0d].rd_vld", tag, k), 6'(o.vld), 6'(e.vld));
        chk($sformatf("%s[%0d].ack", tag, k), 6'(o.ack), 6'(e.ack));
        chk($sformatf("%s[%0d].err", tag, k), 6'(o.err), 6'(e.err));
        chk($sformatf("%s[%0d].busy", tag, k), 6'(o.busy), 6'(e.busy));
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            for (int a = 0; a < 8; a++) mm[k][a] = 6'h3F;
            omem_m[k] = 6'h3F;
            busy_m[k] = 1'b0;
            ptr_m[k]  = 0;
        end
    endtask

    // Predict what each instance shows after the coming edge and queue it.
    task automatic model_push();
        for (int k = 0; k < 2; k++) begin
            exp_t e;
            e.vld = 1'b0; e.ack = 1'b0; e.err = 1'b0;
            if (busy_m[k]) begin
                mm[k][ptr_m[k]] = 6'h3F;
                ptr_m[k]++;
                if (ptr_m[k] == dep[k]) busy_m[k] = 1'b0;
            end else begin
                bit wr_ok, wr_bad;
                wr_ok  = mem_wrt_en && !in_clr && (int'(in_wrt_addr) < dep[k]);
                wr_bad = mem_wrt_en && !in_clr && (int'(in_wrt_addr) >= dep[k]);
                e.ack  = wr_ok;
                e.err  = wr_bad || (in_rd_en && int'(in_rd_addr) >= dep[k]);
                if (in_rd_en) begin
                    e.vld = 1'b1;
                    if (int'(in_rd_addr) >= dep[k])
                        omem_m[k] = 6'h3F;
                    else if (byp[k] && wr_ok && in_rd_addr == in_wrt_addr)
                        omem_m[k] = in_mem;
                    else
                        omem_m[k] = mm[k][in_rd_addr];
                end
                if (wr_ok) mm[k][in_wrt_addr] = in_mem;
                if (in_clr) begin
                    busy_m[k] = 1'b1;
                    ptr_m[k]  = 0;
                end
            end
            e.mem  = omem_m[k];
            e.busy = busy_m[k];
            sb.push_back(e);
        end
    endtask

    task automatic drive(bit wen, int waddr, logic [5:0] wdata, bit ren, int raddr, bit clr);
        mem_wrt_en  = wen;
        in_wrt_addr = 3'(waddr);
        in_mem      = wdata;
        in_rd_en    = ren;
        in_rd_addr  = 3'(raddr);
        in_clr      = clr;
    endtask

    task automatic cycle(string tag);
        model_push();
        @(posedge in_clk);
        #1;
        for (int k = 0; k < 2; k++) begin
            exp_t e;
            e = sb.pop_front();
            cmp(tag, k, e);
        end
    endtask

    task automatic check_reset_state(string tag);
        for (int k = 0; k < 2; k++) begin
            exp_t e;
            e.mem = 6'h3F; e.vld = 1'b0; e.ack = 1'b0; e.err = 1'b0; e.busy = 1'b0;
            cmp(tag, k, e);
        end
    endtask

    int busy_cnt_a, busy_cnt_b;

    initial begin
        in_rst = 1'b0;
        drive(0, 0, 6'h00, 0, 0, 0);
        model_reset();
        repeat (2) @(posedge in_clk);
        #1;
        check_reset_state("reset");
        @(negedge in_clk);
        in_rst = 1'b1;

        for (int a = 0; a < 8; a++) begin
            drive(0, 0, 6'h00, 1, a, 0);
            cycle("rd_after_reset");
        end
        drive(0, 0, 6'h00, 0, 0, 0);
        cycle("idle_hold");

        drive(1, 3, 6'h15, 0, 0, 0);
        cycle("wr3");
        drive(0, 0, 6'h00, 1, 3, 0);
        cycle("rd3");

        drive(1, 5, 6'h0A, 1, 5, 0);
        cycle("collide5");
        drive(0, 0, 6'h00, 1, 5, 0);
        cycle("rd5_after");

        drive(1, 7, 6'h2B, 0, 0, 0);
        cycle("wr7");
        drive(0, 0, 6'h00, 1, 6, 0);
        cycle("rd6");
        drive(1, 6, 6'h11, 1, 7, 0);
        cycle("bad_rw");

        for (int a = 0; a < 8; a++) begin
            drive(1, a, 6'h00, 0, 0, 0);
            cycle("fill0");
        end
        drive(1, 2, 6'h25, 1, 4, 1);
        cycle("clr_wr");
        busy_cnt_a = int'(oa_busy);
        busy_cnt_b = int'(ob_busy);
        for (int i = 0; i < 10; i++) begin
            drive(1, i % 8, 6'($urandom_range(0, 63)), 1, i % 8, i == 3);
            cycle("during_clr");
            busy_cnt_a += int'(oa_busy);
            busy_cnt_b += int'(ob_busy);
        end
        chk("busy_cycles_a", 6'(busy_cnt_a), 6'd8);
        chk("busy_cycles_b", 6'(busy_cnt_b), 6'd6);
        for (int a = 0; a < 8; a++) begin
            drive(0, 0, 6'h00, 1, a, 0);
            cycle("rd_after_clr");
        end

        drive(1, 1, 6'h07, 0, 0, 0);
        cycle("pre_clr2");
        drive(0, 0, 6'h00, 0, 0, 1);
        cycle("clr2");
        drive(0, 0, 6'h00, 0, 0, 0);
        for (int i = 0; i < 3; i++) cycle("clr2_run");
        in_rst = 1'b0;
        #1;
        model_reset();
        check_reset_state("rst_mid_clr");
        @(negedge in_clk);
        in_rst = 1'b1;
        drive(1, 4, 6'h2A, 0, 0, 0);
        cycle("post_rst_wr");
        drive(0, 0, 6'h00, 1, 4, 0);
        cycle("post_rst_rd4");
        drive(0, 0, 6'h00, 1, 1, 0);
        cycle("post_rst_rd1");

        for (int i = 0; i < 60; i++) begin
            drive($urandom_range(0, 1), $urandom_range(0, 7), 6'($urandom_range(0, 63)),
                  $urandom_range(0, 1), $urandom_range(0, 7), $urandom_range(0, 15) == 0);
            cycle("rand");
        end
        drive(0, 0, 6'h00, 0, 0, 0);
        for (int i = 0; i < 10; i++) cycle("drain");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
